h_program_counter: RTL

WIDTH-bit program counter for the CPU datapath. Feeds the instruction-memory address port and is driven by the jump/branch logic built from the base gate library (hNot, hAnd, hMux). Each rising clock edge it resets, loads a jump target, increments, or holds, under a fixed priority. It also flags increment wrap-around and raises a one-cycle jump pulse for the fetch stage.

---
 rtl/h_program_counter_pkg.sv | 23 ++
 rtl/h_register.sv | 18 +
 rtl/h_program_counter.sv | 66 ++++++
 3 files changed

// File: rtl/h_program_counter_pkg.sv
// Shared constants and op-select encoding for the program counter,
// its jump-control logic and the bench model.
package h_program_counter_pkg;

    localparam int          DEFAULT_WIDTH        = 16;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_LOAD  = 2'd1,
        OP_INC   = 2'd2,
        OP_HOLD  = 2'd3
    } pc_op_e;

    // Fixed priority: reset > load > inc > hold.
    function automatic pc_op_e pc_select(input logic reset, input logic load, input logic inc);
        if (reset)     return OP_RESET;
        else if (load) return OP_LOAD;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/h_register.sv
// WIDTH-bit register with load enable and synchronous reset to RESET_VALUE.
module h_register #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= RESET_VALUE;
        else if (en) q <= d;
    end

endmodule

// File: rtl/h_program_counter.sv
// Program counter: reset / load / increment / hold with registered
// wrap-around and jump pulses.
module h_program_counter
    import h_program_counter_pkg::*;
#(
    parameter int          WIDTH        = DEFAULT_WIDTH,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             wrapped,
    output logic             jumped
);

    localparam logic [WIDTH-1:0] RV = RESET_VECTOR[WIDTH-1:0];

    pc_op_e           op;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] pc_next;
    logic             pc_en;

    // One extra bit on the adder: its carry is the sole source of wrapped.
    always_comb begin
        op      = pc_select(reset, load, inc);
        inc_sum = {1'b0, out} + {{WIDTH{1'b0}}, 1'b1};
        pc_next = out;
        pc_en   = 1'b0;
        case (op)
            OP_LOAD: begin
                pc_next = in;
                pc_en   = 1'b1;
            end
            OP_INC: begin
                pc_next = inc_sum[WIDTH-1:0];
                pc_en   = 1'b1;
            end
            default: ;
        endcase
    end

    h_register #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RV)
    ) u_pc (
        .clk  (clk),
        .reset(reset),
        .en   (pc_en),
        .d    (pc_next),
        .q    (out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wrapped <= 1'b0;
            jumped  <= 1'b0;
        end else begin
            wrapped <= (op == OP_INC) && inc_sum[WIDTH];
            jumped  <= (op == OP_LOAD);
        end
    end

endmodule
